// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: entry layout, pointer
// width and the word-address slice used for store-to-load matching.
package store_buffer_pkg;

  localparam int SB_DATA_WIDTH = 32;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DEPTH      = 4;
  localparam int PTR_W         = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
  } sb_entry_t;

  // Entries match on whole words, so the byte offset bits are dropped.
  function automatic logic [SB_ADDR_WIDTH-3:0] word_addr(input logic [SB_ADDR_WIDTH-1:0] byte_addr);
    return byte_addr[SB_ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Age-ordered priority matcher: walks the FIFO from oldest (head) to
// youngest, so the last valid match seen is the youngest pending store.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                entries [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [PTR_W-1:0]         head,
  input  logic [SB_ADDR_WIDTH-1:0] lookup_addr,
  output logic                     hit,
  output logic [PTR_W-1:0]         hit_idx
);

  // Scan in age order; a younger match overrides any older one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (word_addr(entries[idx].addr) == word_addr(lookup_addr))) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of the single-ported data memory. Stores are queued
// and drained one per cycle while no load needs the port; loads are served
// from the youngest matching pending store, otherwise from memory.
// Entry widths come from the package; the width parameters must keep
// their package defaults.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DEPTH      = SB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_ready,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic                  empty,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] valid;
  logic             full;
  logic             enq;
  logic             deq;
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_idx;

  // Readiness depends on occupancy only, so a full buffer never accepts a
  // store even when an entry leaves in the same cycle.
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign st_ready = !full;
  assign enq      = st_valid && st_ready;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] offset;
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - head;
      valid[i] = ({1'b0, offset} < count);
    end
  end

  store_buffer_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .entries    (entries),
    .valid      (valid),
    .head       (head),
    .lookup_addr(ld_addr),
    .hit        (fwd_hit),
    .hit_idx    (fwd_idx)
  );

  // Port arbitration: a full buffer forces a drain over a load, otherwise
  // loads own the port and stores drain only in load-free cycles.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    ld_stall = 1'b0;
    deq      = 1'b0;
    if (full && ld_req) begin
      ld_stall = 1'b1;
      mem_we   = 1'b1;
      mem_addr = entries[head].addr;
      mem_wd   = entries[head].data;
      deq      = 1'b1;
    end else if (ld_req) begin
      mem_addr = ld_addr;
    end else if (!empty) begin
      mem_we   = 1'b1;
      mem_addr = entries[head].addr;
      mem_wd   = entries[head].data;
      deq      = 1'b1;
    end
  end

  // A draining entry is still live this cycle, so it can still forward.
  assign ld_data = fwd_hit ? entries[fwd_idx].data : mem_rd;

  // FIFO state: enqueue at tail, dequeue at head; reset drops pending stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (enq) begin
        entries[tail].addr <= st_addr;
        entries[tail].data <= st_data;
        tail               <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (deq && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
